// File: rtl/ssp_rx_shifter.sv
// SSP serial receive shifter: synchronises the serial clock, frame sync and data into PCLK, assembles MSB-first frames, pushes them to the RxFIFO and flags overrun.
// Optional loopback inputs are compiled in with `define SSP_RX_LOOPBACK_EN.
module ssp_rx_shifter #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  CLEAR_B,
  input  logic                  SSE,
  input  logic                  SSPCLKIN,
  input  logic                  SSPFSSIN,
  input  logic                  SSPRXD,
`ifdef SSP_RX_LOOPBACK_EN
  input  logic                  LBM,
  input  logic                  SSPTXD,
  input  logic                  SSPCLKOUT,
  input  logic                  SSPFSSOUT,
`endif
  input  logic                  RX_FULL,
  input  logic                  RORIC,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  WRITE_RX,
  output logic                  SSPRORINTR,
  output logic                  RX_BUSY
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic clk_src;
  logic fss_src;
  logic rxd_src;

`ifdef SSP_RX_LOOPBACK_EN
  assign clk_src = LBM ? SSPCLKOUT : SSPCLKIN;
  assign fss_src = LBM ? SSPFSSOUT : SSPFSSIN;
  assign rxd_src = LBM ? SSPTXD    : SSPRXD;
`else
  assign clk_src = SSPCLKIN;
  assign fss_src = SSPFSSIN;
  assign rxd_src = SSPRXD;
`endif

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] fss_sync_q;
  logic [SYNC_STAGES-1:0] rxd_sync_q;
  logic                   clk_prev_q;

  // All three inputs see the same depth so data and frame sync stay aligned to the clock edge.
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      clk_sync_q <= '0;
      fss_sync_q <= '0;
      rxd_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], clk_src};
      fss_sync_q <= {fss_sync_q[SYNC_STAGES-2:0], fss_src};
      rxd_sync_q <= {rxd_sync_q[SYNC_STAGES-2:0], rxd_src};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  logic clk_s;
  logic fss_s;
  logic rxd_s;
  logic sample_ev;

  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign fss_s     = fss_sync_q[SYNC_STAGES-1];
  assign rxd_s     = rxd_sync_q[SYNC_STAGES-1];
  assign sample_ev = clk_prev_q & ~clk_s;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] rxdata_q;
  logic                  write_q;
  logic                  ror_q;
  logic                  ror_d;

  // A fresh overrun outranks a simultaneous clear.
  assign ror_d = (done_q & RX_FULL) | (ror_q & ~RORIC);

  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      done_q   <= 1'b0;
      rxdata_q <= '0;
      write_q  <= 1'b0;
      ror_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      write_q <= 1'b0;
      ror_q   <= ror_d;
      if (done_q && !RX_FULL) begin
        rxdata_q <= shreg_q;
        write_q  <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (sample_ev && fss_s && SSE) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (!SSE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (sample_ev) begin
            shreg_q <= {shreg_q[DATA_WIDTH-2:0], rxd_s};
            if (cnt_q == LAST_BIT) begin
              done_q <= 1'b1;
              cnt_q  <= '0;
              if (!fss_s) begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign RxData     = rxdata_q;
  assign WRITE_RX   = write_q;
  assign SSPRORINTR = ror_q;
  assign RX_BUSY    = (state_q == SHIFT);

endmodule

// File: tb/tb_ssp_rx_shifter.sv
// Directed bench for ssp_rx_shifter: serial clock at PCLK/8, hand-computed frames and flags.
`timescale 1ns/1ps
module tb_ssp_rx_shifter;

  logic       PCLK = 1'b0;
  logic       CLEAR_B;
  logic       SSE;
  logic       SSPCLKIN;
  logic       SSPFSSIN;
  logic       SSPRXD;
  logic       LBM;
  logic       SSPTXD;
  logic       SSPCLKOUT;
  logic       SSPFSSOUT;
  logic       RX_FULL;
  logic       RORIC;
  logic [7:0] RxData;
  logic       WRITE_RX;
  logic       SSPRORINTR;
  logic       RX_BUSY;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [7:0] wr_q[$];
  logic lbm_mode = 1'b0;
  logic mon_on = 1'b0;
  logic busy_low = 1'b0;

  always #5 PCLK = ~PCLK;

  ssp_rx_shifter #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .PCLK       (PCLK),
    .CLEAR_B    (CLEAR_B),
    .SSE        (SSE),
    .SSPCLKIN   (SSPCLKIN),
    .SSPFSSIN   (SSPFSSIN),
    .SSPRXD     (SSPRXD),
`ifdef SSP_RX_LOOPBACK_EN
    .LBM        (LBM),
    .SSPTXD     (SSPTXD),
    .SSPCLKOUT  (SSPCLKOUT),
    .SSPFSSOUT  (SSPFSSOUT),
`endif
    .RX_FULL    (RX_FULL),
    .RORIC      (RORIC),
    .RxData     (RxData),
    .WRITE_RX   (WRITE_RX),
    .SSPRORINTR (SSPRORINTR),
    .RX_BUSY    (RX_BUSY)
  );

  always @(negedge PCLK) begin
    if (WRITE_RX === 1'b1) begin
      wr_cnt++;
      wr_q.push_back(RxData);
    end
    if (mon_on && RX_BUSY !== 1'b1) busy_low = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge PCLK);
      if (lbm_mode) begin
        SSPCLKIN = 1'($urandom_range(0, 1));
        SSPFSSIN = 1'($urandom_range(0, 1));
        SSPRXD   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic drive(input logic c, input logic f, input logic d);
    if (lbm_mode) begin
      SSPCLKOUT = c; SSPFSSOUT = f; SSPTXD = d;
    end else begin
      SSPCLKIN = c; SSPFSSIN = f; SSPRXD = d;
    end
  endtask

  task automatic sbit(input logic f, input logic d);
    drive(1'b1, f, d);
    cyc(4);
    drive(1'b0, f, d);
    cyc(4);
  endtask

  task automatic send_fss();
    sbit(1'b1, 1'b0);
  endtask

  // Sends the top n bits of d, MSB first; FSS rides on the last one when requested.
  task automatic send_bits(input logic [7:0] d, input int n, input logic last_fss);
    logic [7:0] s;
    s = d;
    for (int i = 0; i < n; i++) begin
      sbit((i == n - 1) ? last_fss : 1'b0, s[7]);
      s = {s[6:0], 1'b0};
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic [7:0] exp_b2b [3];
    exp_b2b[0] = 8'h01; exp_b2b[1] = 8'h02; exp_b2b[2] = 8'h03;
    CLEAR_B = 1'b0; SSE = 1'b0; RX_FULL = 1'b0; RORIC = 1'b0; LBM = 1'b0;
    SSPCLKIN = 1'b0; SSPFSSIN = 1'b0; SSPRXD = 1'b0;
    SSPCLKOUT = 1'b0; SSPFSSOUT = 1'b0; SSPTXD = 1'b0;
    cyc(3);
    check("rst_write", 32'(WRITE_RX), 32'h0);
    check("rst_rxdata", 32'(RxData), 32'h0);
    check("rst_ror", 32'(SSPRORINTR), 32'h0);
    check("rst_busy", 32'(RX_BUSY), 32'h0);
    CLEAR_B = 1'b1; SSE = 1'b1;
    cyc(4);

    // Single frame A5
    base = wr_cnt;
    send_fss();
    send_bits(8'hA5, 4, 1'b0);
    check("a5_busy_mid", 32'(RX_BUSY), 32'h1);
    send_bits(8'h50, 4, 1'b0);
    cyc(10);
    check("a5_pushes", 32'(wr_cnt - base), 32'h1);
    check("a5_rxdata", 32'(RxData), 32'hA5);
    check("a5_busy_after", 32'(RX_BUSY), 32'h0);

    // Back-to-back 01, 02, 03
    base = wr_cnt;
    wr_q.delete();
    busy_low = 1'b0;
    send_fss();
    send_bits(8'h01, 1, 1'b0);
    mon_on = 1'b1;
    send_bits(8'h02, 7, 1'b1);
    send_bits(8'h02, 8, 1'b1);
    send_bits(8'h03, 7, 1'b0);
    mon_on = 1'b0;
    send_bits(8'h80, 1, 1'b0);
    cyc(10);
    check("b2b_pushes", 32'(wr_cnt - base), 32'h3);
    for (int i = 0; i < 3; i++)
      check("b2b_data", (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hDEAD, 32'(exp_b2b[i]));
    check("b2b_busy_cont", 32'(busy_low), 32'h0);

    // Overrun with RX_FULL, clear, then clear coincident with a new overrun
    base = wr_cnt;
    RX_FULL = 1'b1;
    send_fss();
    send_bits(8'h3C, 8, 1'b0);
    cyc(10);
    check("ovr_no_push", 32'(wr_cnt - base), 32'h0);
    check("ovr_rxdata_hold", 32'(RxData), 32'h03);
    check("ovr_flag_set", 32'(SSPRORINTR), 32'h1);
    RORIC = 1'b1;
    cyc(1);
    RORIC = 1'b0;
    cyc(1);
    check("ovr_flag_clr", 32'(SSPRORINTR), 32'h0);
    send_fss();
    send_bits(8'h3C, 7, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    cyc(4);
    drive(1'b0, 1'b0, 1'b0);
    cyc(3);
    RORIC = 1'b1;
    cyc(1);
    RORIC = 1'b0;
    cyc(6);
    check("ovr_set_wins", 32'(SSPRORINTR), 32'h1);
    check("ovr_no_push2", 32'(wr_cnt - base), 32'h0);
    RX_FULL = 1'b0;

    // SSE abort after 4 bits, then full 81
    base = wr_cnt;
    send_fss();
    send_bits(8'hFF, 4, 1'b0);
    SSE = 1'b0;
    cyc(4);
    check("abort_busy", 32'(RX_BUSY), 32'h0);
    SSE = 1'b1;
    cyc(4);
    send_fss();
    send_bits(8'h81, 8, 1'b0);
    cyc(10);
    check("abort_pushes", 32'(wr_cnt - base), 32'h1);
    check("abort_rxdata", 32'(RxData), 32'h81);

    // Reset mid-frame after 5 bits, then 5A
    base = wr_cnt;
    send_fss();
    send_bits(8'hF0, 5, 1'b0);
    CLEAR_B = 1'b0;
    cyc(1);
    check("mrst_write", 32'(WRITE_RX), 32'h0);
    check("mrst_rxdata", 32'(RxData), 32'h0);
    check("mrst_ror", 32'(SSPRORINTR), 32'h0);
    check("mrst_busy", 32'(RX_BUSY), 32'h0);
    CLEAR_B = 1'b1;
    cyc(4);
    send_fss();
    send_bits(8'h5A, 8, 1'b0);
    cyc(10);
    check("mrst_pushes", 32'(wr_cnt - base), 32'h1);
    check("mrst_rxdata2", 32'(RxData), 32'h5A);

`ifdef SSP_RX_LOOPBACK_EN
    base = wr_cnt;
    lbm_mode = 1'b1;
    LBM = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    cyc(4);
    send_fss();
    send_bits(8'hC3, 8, 1'b0);
    cyc(10);
    check("lbm_pushes", 32'(wr_cnt - base), 32'h1);
    check("lbm_rxdata", 32'(RxData), 32'hC3);
    lbm_mode = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ssp_rx_shifter.md
SSP_RX_SHIFTER -- requirements
Module: ssp_rx_shifter

Interface
REQ-001 Parameter: DATA_WIDTH, 8, frame length in bits and width of RxData.
REQ-002 Parameter: SYNC_STAGES, 2, number of synchronizer flops on each serial input (minimum 2).
REQ-003 Port: PCLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: CLEAR_B  in  1  reset, synchronous, active-low.
REQ-005 Port: SSE  in  1  receiver enable; 0 forces IDLE.
REQ-006 Port: SSPCLKIN  in  1  serial clock, asynchronous to PCLK.
REQ-007 Port: SSPFSSIN  in  1  frame sync, active-high, one serial-clock period wide.
REQ-008 Port: SSPRXD  in  1  serial data, MSB first.
REQ-009 Port: RX_FULL  in  1  downstream RxFIFO full flag.
REQ-010 Port: RORIC  in  1  one-cycle pulse that clears overrun.
REQ-011 Port: RxData  out  DATA_WIDTH  assembled byte presented to the RxFIFO.
REQ-012 Port: WRITE_RX  out  1  one-PCLK push strobe to the RxFIFO (drives its PWRITE_RX path).
REQ-013 Port: SSPRORINTR  out  1  sticky receive-overrun flag.
REQ-014 Port: RX_BUSY  out  1  high while state is SHIFT.

Function
REQ-015 SSPCLKIN, SSPFSSIN and SSPRXD SHALL each pass through SYNC_STAGES flops before use; the serial clock high and low phases SHALL each be at least SYNC_STAGES+1 PCLK periods.
REQ-016 A sample event SHALL occur in the PCLK cycle where the synchronized SSPCLKIN is 0 and its previous-cycle value was 1 (falling edge).
REQ-017 FSM states: IDLE, SHIFT; 4-bit-wide-enough bit counter cnt.
REQ-018 IDLE -> SHIFT on a sample event with synchronized SSPFSSIN=1 and SSE=1; cnt cleared to 0; no data captured on that event.
REQ-019 In SHIFT each sample event SHALL shift synchronized SSPRXD into the shift register LSB, with prior contents moved toward the MSB, and SHALL increment cnt.
REQ-020 On the sample event that captures bit DATA_WIDTH (cnt = DATA_WIDTH-1): if synchronized SSPFSSIN=1, remain in SHIFT with cnt=0 (back-to-back frame); otherwise go to IDLE.
REQ-021 In the PCLK cycle after the completing sample event: if RX_FULL=0, RxData SHALL load the assembled byte and WRITE_RX SHALL be 1 for exactly one cycle; if RX_FULL=1, RxData and WRITE_RX are unchanged/0 and SSPRORINTR SHALL set.
REQ-022 RxData SHALL hold its last pushed value between strobes.
REQ-023 SSPRORINTR SHALL stay 1 until a cycle with RORIC=1; if set and clear coincide, set wins.
REQ-024 SSE=0 in SHIFT SHALL abort the frame next cycle: state IDLE, partial byte discarded, no WRITE_RX; SSPRORINTR is unaffected.
REQ-025 SSPFSSIN pulses sampled in SHIFT before the last bit SHALL be ignored.
REQ-026 The RX_FULL value sampled in the push cycle alone decides push vs. overrun.

Reset
REQ-027 With CLEAR_B=0 at a PCLK edge: state IDLE, cnt 0, shift register 0, RxData 0, WRITE_RX 0, SSPRORINTR 0, RX_BUSY 0; synchronizer flops SHALL reset to 0.
REQ-028 Reset mid-frame SHALL discard the partial byte with no WRITE_RX; the first post-reset frame starts only from a fresh FSS sample event.

Configuration
REQ-029 Macro SSP_RX_LOOPBACK_EN: when defined, ports LBM, SSPTXD, SSPCLKOUT and SSPFSSOUT (all in, 1 bit) exist; LBM=1 selects SSPTXD/SSPCLKOUT/SSPFSSOUT in place of SSPRXD/SSPCLKIN/SSPFSSIN ahead of the synchronizers.
REQ-030 When SSP_RX_LOOPBACK_EN is undefined, those ports SHALL be absent and behaviour SHALL equal LBM=0.

Verification
REQ-031 SSPCLKIN at PCLK/8, FSS pulse, then bits of 8'hA5, RX_FULL=0 -> exactly one WRITE_RX pulse with RxData=8'hA5; RX_BUSY high during the frame, low afterwards.
REQ-032 Back-to-back frames 8'h01, 8'h02, 8'h03, each with FSS high during the previous LSB -> three WRITE_RX pulses carrying 01, 02, 03 in order, with RX_BUSY continuously high.
REQ-033 Frame 8'h3C with RX_FULL=1 -> no WRITE_RX, RxData retains its old value, SSPRORINTR=1; RORIC pulse -> 0; RORIC coincident with a new overrun -> stays 1.
REQ-034 SSE dropped after 4 bits of 8'hFF, then SSE=1 and a full frame 8'h81 -> single WRITE_RX, RxData=8'h81.
REQ-035 CLEAR_B=0 for one cycle after 5 bits -> all outputs 0 next cycle; next complete frame 8'h5A is received correctly.
REQ-036 With SSP_RX_LOOPBACK_EN defined, LBM=1, frame 8'hC3 driven on SSPTXD/SSPCLKOUT/SSPFSSOUT and noise on the external pins -> RxData=8'hC3.
